// File: rtl/rom_refill_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_refill_responder_pkg
//  Purpose  : Shared constants for the ROM refill responder and its Icache
//             peer: FSM state encodings and ROM geometry.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rom_refill_responder_pkg;

    // Refill FSM state encodings (2 bits)
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_read = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // ROM geometry shared with the Icache
    localparam logic [31:0]  c_rom_base_addr  = 32'h0000_0000;
    localparam int unsigned  c_rom_data_w     = 32;
    localparam int unsigned  c_rom_aw_default = 10;

endpackage
`default_nettype wire

// File: rtl/rom_refill_responder_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : refill_line_buf
//  Purpose  : LINE_WORDS x DATA_W register file collecting one cache line.
//             One indexed write port, whole line visible on a flat bus.
//  Ports    : clk, rst_n          clock / async active-low reset
//             i_wr_en, i_wr_idx   write strobe and word slot
//             i_wr_data           word to store
//             o_line              word k at bits [DATA_W*k +: DATA_W]
//  Revision : 1.0  initial release
// ============================================================================
module refill_line_buf #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0]              i_wr_data,
    output logic [DATA_W*LINE_WORDS-1:0]   o_line
);

    localparam int unsigned c_idx_w = $clog2(LINE_WORDS);

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_word
        logic [DATA_W-1:0] r_word;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (i_wr_en && (i_wr_idx == c_idx_w'(k))) begin
                r_word <= i_wr_data;
            end
        end

        assign o_line[DATA_W*k +: DATA_W] = r_word;
    end

endmodule
`default_nettype wire

// File: rtl/rom_refill_responder.sv
`default_nettype none
// ============================================================================
//  Module   : rom_refill_responder
//  Purpose  : Memory-side responder for Icache line refills. Accepts a miss,
//             waits LATENCY cycles, reads LINE_WORDS words from a synchronous
//             ROM into a line buffer and pulses rom_ready_o for one cycle.
//  Ports    : clk, rst_n                       clock / async active-low reset
//             icache_req_i, icache_addr_i      miss request and byte address
//             rom_en_o, rom_addr_o, rom_rdata_i synchronous ROM read port
//             rom_ready_o                      one-cycle refill-done pulse
//             rom_busy_o                       high whenever not IDLE
//             rom_line_o, rom_line_addr_o      assembled line and its base
//  Config   : ROM_CRIT_WORD_FIRST_EN - when defined, beats start at the
//             requested word and wrap inside the line; otherwise 0..N-1.
//  Revision : 1.0  initial release
// ============================================================================
module rom_refill_responder
    import rom_refill_responder_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned ROM_AW     = c_rom_aw_default
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                icache_req_i,
    input  logic [31:0]                         icache_addr_i,
    output logic                                rom_en_o,
    output logic [ROM_AW-1:0]                   rom_addr_o,
    input  logic [c_rom_data_w-1:0]             rom_rdata_i,
    output logic                                rom_ready_o,
    output logic                                rom_busy_o,
    output logic [c_rom_data_w*LINE_WORDS-1:0]  rom_line_o,
    output logic [31:0]                         rom_line_addr_o
);

    localparam int unsigned c_idx_w  = $clog2(LINE_WORDS);
    localparam int unsigned c_beat_w = c_idx_w + 1;
    localparam int unsigned c_cnt_w  = (LATENCY <= 2) ? 1 : $clog2(LATENCY);
    localparam logic [c_cnt_w-1:0]  c_lat_init  = c_cnt_w'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [31:0]         c_line_mask = ~(32'(4 * LINE_WORDS) - 32'd1);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(LINE_WORDS);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_cnt_w-1:0]  r_lat_cnt;
    logic [c_beat_w-1:0] r_beat;
    logic [31:0]         r_base;
    logic [c_idx_w-1:0]  w_start;
    logic                w_accept;
    logic                w_issue;
    logic                w_capture;
    logic [c_idx_w-1:0]  w_issue_slot;
    logic [c_idx_w-1:0]  w_cap_slot;

    assign w_accept = (r_state == c_st_idle) && icache_req_i;

`ifdef ROM_CRIT_WORD_FIRST_EN
    logic [c_idx_w-1:0] r_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= '0;
        end else if (w_accept) begin
            r_start <= icache_addr_i[c_idx_w+1:2];
        end
    end

    assign w_start = r_start;
`else
    assign w_start = '0;
`endif

    // Slot arithmetic is modulo LINE_WORDS by truncation, so beats wrap inside
    // the line. Data returned in beat b lands in the slot issued in beat b-1.
    assign w_issue_slot = r_beat[c_idx_w-1:0] + w_start;
    assign w_cap_slot   = w_issue_slot - c_idx_w'(1);
    assign w_issue      = (r_state == c_st_read) && (r_beat != c_last_beat);
    assign w_capture    = (r_state == c_st_read) && (r_beat != '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (icache_req_i) w_next_state = (LATENCY == 0) ? c_st_read : c_st_wait;
            c_st_wait: if (r_lat_cnt == '0) w_next_state = c_st_read;
            c_st_read: if (r_beat == c_last_beat) w_next_state = c_st_done;
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        rom_en_o    = w_issue;
        rom_addr_o  = '0;
        if (w_issue) begin
            // Base is line aligned, so adding the slot never carries out of the line.
            rom_addr_o = r_base[ROM_AW+1:2] + ROM_AW'(w_issue_slot);
        end
        rom_ready_o = (r_state == c_st_done);
        rom_busy_o  = (r_state != c_st_idle);
    end

    // ------------------------------------------------------ counters / base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base    <= '0;
            r_lat_cnt <= '0;
            r_beat    <= '0;
        end else if (w_accept) begin
            r_base    <= icache_addr_i & c_line_mask;
            r_lat_cnt <= c_lat_init;
            r_beat    <= '0;
        end else begin
            if ((r_state == c_st_wait) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - c_cnt_w'(1);
            end
            if (r_state == c_st_read) begin
                r_beat <= r_beat + c_beat_w'(1);
            end
        end
    end

    assign rom_line_addr_o = r_base;

    refill_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (c_rom_data_w)
    ) u_line_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_capture),
        .i_wr_idx   (w_cap_slot),
        .i_wr_data  (rom_rdata_i),
        .o_line     (rom_line_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_rom_refill_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_refill_responder
//  Purpose  : Directed self-checking bench. Two responders (LATENCY=3 and
//             LATENCY=0, LINE_WORDS=4) each face a ROM model where word w
//             holds value w.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_refill_responder;

`ifdef ROM_CRIT_WORD_FIRST_EN
    localparam int c_cwf = 1;
`else
    localparam int c_cwf = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         req0, req1;
    logic [31:0]  addr0, addr1;
    logic         rom_en0, rom_en1;
    logic [9:0]   rom_addr0, rom_addr1;
    logic [31:0]  rom_rdata0, rom_rdata1;
    logic         rdy0, rdy1, busy0, busy1;
    logic [127:0] line0, line1;
    logic [31:0]  line_addr0, line_addr1;

    int n_checks = 0;
    int n_errors = 0;

    int         first_en, n_en, ready_cyc, last_ready, n_ready, consec;
    logic [9:0] en_addr [0:15];
    bit         busy_tr [0:31];

    rom_refill_responder #(.LINE_WORDS(4), .LATENCY(3), .ROM_AW(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .icache_req_i(req0), .icache_addr_i(addr0),
        .rom_en_o(rom_en0), .rom_addr_o(rom_addr0), .rom_rdata_i(rom_rdata0),
        .rom_ready_o(rdy0), .rom_busy_o(busy0), .rom_line_o(line0),
        .rom_line_addr_o(line_addr0)
    );

    rom_refill_responder #(.LINE_WORDS(4), .LATENCY(0), .ROM_AW(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .icache_req_i(req1), .icache_addr_i(addr1),
        .rom_en_o(rom_en1), .rom_addr_o(rom_addr1), .rom_rdata_i(rom_rdata1),
        .rom_ready_o(rdy1), .rom_busy_o(busy1), .rom_line_o(line1),
        .rom_line_addr_o(line_addr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: word w holds value w.
    always @(posedge clk) begin
        if (rom_en0) rom_rdata0 <= 32'(rom_addr0);
        if (rom_en1) rom_rdata1 <= 32'(rom_addr1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input int w0);
        return {32'(w0 + 3), 32'(w0 + 2), 32'(w0 + 1), 32'(w0)};
    endfunction

    task automatic drive(input int sel, input logic r, input logic [31:0] a);
        if (sel == 0) begin req0 = r; addr0 = a; end
        else          begin req1 = r; addr1 = a; end
    endtask

    // Raise req in cycle 0, then sample cycles 1..ncyc. The address switches
    // to a2 after the sample of cycle swap_cyc; req drops after the n_req-th
    // ready pulse.
    task automatic do_refill(input int sel, input logic [31:0] a, input logic [31:0] a2,
                             input int swap_cyc, input int n_req, input int ncyc);
        logic en, rdy, bsy, prev, rq;
        logic [9:0] ad;
        logic [31:0] cur;
        first_en = -1; n_en = 0; ready_cyc = -1; last_ready = -1;
        n_ready = 0; consec = 0; prev = 1'b0; rq = 1'b1; cur = a;
        @(negedge clk);
        drive(sel, 1'b1, a);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (sel == 0) begin en = rom_en0; ad = rom_addr0; rdy = rdy0; bsy = busy0; end
            else          begin en = rom_en1; ad = rom_addr1; rdy = rdy1; bsy = busy1; end
            if (c < 32) busy_tr[c] = bsy;
            if (en) begin
                if (first_en < 0) first_en = c;
                if (n_en < 16) en_addr[n_en] = ad;
                n_en++;
            end
            if (rdy) begin
                if (prev) consec++;
                n_ready++;
                if (ready_cyc < 0) ready_cyc = c;
                last_ready = c;
                if (n_ready == n_req) rq = 1'b0;
            end
            prev = rdy;
            if (c == swap_cyc) cur = a2;
            drive(sel, rq, cur);
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  {126'b0, busy0, rom_en0}, 128'h0);
        check("reset_ready", {127'b0, rdy0}, 128'h0);
        check("reset_line",  line0, 128'h0);
        check("reset_laddr", {96'b0, line_addr0, 22'b0, rom_addr0} , 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1 basic
        do_refill(0, 32'h0000_0010, 32'h0000_0010, 0, 1, 12);
        check("t1_first_en", 128'(first_en), 128'd4);
        check("t1_n_en",     128'(n_en), 128'd4);
        for (int k = 0; k < 4; k++) check("t1_addr", 128'(en_addr[k]), 128'(4 + k));
        check("t1_ready_cyc", 128'(ready_cyc), 128'd9);
        check("t1_n_ready",   128'(n_ready), 128'd1);
        check("t1_busy_done", 128'(busy_tr[9]), 128'd1);
        check("t1_busy_idle", 128'(busy_tr[10]), 128'd0);
        check("t1_line",      line0, line_of(4));
        check("t1_laddr",     128'(line_addr0), 128'h10);

        // T2 back-to-back, req held across DONE; second address 0x34
        do_refill(0, 32'h0000_0020, 32'h0000_0034, 9, 2, 22);
        check("t2_ready_first",  128'(ready_cyc), 128'd9);
        check("t2_ready_second", 128'(last_ready), 128'd19);
        check("t2_n_ready",      128'(n_ready), 128'd2);
        check("t2_consec",       128'(consec), 128'd0);
        check("t2_n_en",         128'(n_en), 128'd8);
        check("t2_line",         line0, line_of(12));
        check("t2_laddr",        128'(line_addr0), 128'h30);

        // T3 critical word: offset 2
        do_refill(0, 32'h0000_0018, 32'h0000_0018, 0, 1, 12);
        for (int k = 0; k < 4; k++)
            check("t3_addr", 128'(en_addr[k]), 128'(4 + ((k + 2 * c_cwf) % 4)));
        check("t3_line",  line0, line_of(4));
        check("t3_laddr", 128'(line_addr0), 128'h10);

        // T6 address changes during WAIT are ignored
        do_refill(0, 32'h0000_0044, 32'h0000_03F0, 2, 1, 12);
        check("t6_first_addr", 128'(en_addr[0]), 128'(16 + c_cwf));
        check("t6_ready_cyc",  128'(ready_cyc), 128'd9);
        check("t6_line",       line0, line_of(16));
        check("t6_laddr",      128'(line_addr0), 128'h40);

        // T7 upper address bits beyond ROM_AW are truncated
        do_refill(0, 32'h1000_0020, 32'h1000_0020, 0, 1, 12);
        check("t7_first_addr", 128'(en_addr[0]), 128'd8);
        check("t7_line",       line0, line_of(8));
        check("t7_laddr",      128'(line_addr0), 128'h1000_0020);

        // T4 reset abort in cycle 5
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_0050);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
        end
        check("t4_pre_en", 128'(rom_en0), 128'd1);
        rst_n = 1'b0;
        drive(0, 1'b0, 32'h0000_0050);
        #1;
        check("t4_abort_ctl",   {124'b0, rom_en0, rdy0, busy0, 1'b0}, 128'h0);
        check("t4_abort_addr",  128'(rom_addr0), 128'h0);
        check("t4_abort_line",  line0, 128'h0);
        check("t4_abort_laddr", 128'(line_addr0), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (rdy0 || busy0) cnt++;
        end
        check("t4_no_ready", 128'(cnt), 128'd0);
        do_refill(0, 32'h0000_0060, 32'h0000_0060, 0, 1, 12);
        check("t4_ready_cyc", 128'(ready_cyc), 128'd9);
        check("t4_line",      line0, line_of(24));

        // T5 LATENCY=0 instance
        do_refill(1, 32'h0000_0074, 32'h0000_0074, 0, 1, 10);
        check("t5_first_en",   128'(first_en), 128'd1);
        check("t5_first_addr", 128'(en_addr[0]), 128'(28 + c_cwf));
        check("t5_ready_cyc",  128'(ready_cyc), 128'd6);
        check("t5_n_ready",    128'(n_ready), 128'd1);
        check("t5_line",       line1, line_of(28));
        check("t5_laddr",      128'(line_addr1), 128'h70);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
